// File: rtl/reg_file_pkg.sv
// Shared constants and types for the reg_file_rd register file.
// The optional write-to-read forwarding path is selected with RF_BYPASS_EN.
package reg_file_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_DEPTH  = 8;
    localparam int RF_ADDR_W = 3;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    localparam rf_addr_t RF_ZERO_REG = '0;

endpackage

// File: rtl/rf_entry.sv
// One register-file entry: a W-bit register with load enable and
// synchronous active-low reset.
module rf_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/reg_file_rd.sv
// 8x8 register file, one write port and two registered read ports.
// Build with RF_BYPASS_EN for write-through forwarding; default is read-before-write.
module reg_file_rd
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b
);

    logic [DATA_W-1:0] entry_q [DEPTH];

    // Entry 0 is a constant, so writes to it simply have nowhere to land.
    assign entry_q[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
        rf_entry #(.W(DATA_W)) u_entry (
            .clk   (clk),
            .reset (reset),
            .en    (we && (waddr == ADDR_W'(i))),
            .d     (wdata),
            .q     (entry_q[i])
        );
    end

    // Read handshake: rvalid_x is high for exactly the cycle after an edge
    // that sampled rd_en_x=1; rdata_x is only meaningful while rvalid_x is
    // high and otherwise holds the last word read.
    logic [DATA_W-1:0] rword_a;
    logic [DATA_W-1:0] rword_b;
    logic [DATA_W-1:0] rdata_a_d, rdata_a_q;
    logic [DATA_W-1:0] rdata_b_d, rdata_b_q;
    logic              rvalid_a_d, rvalid_a_q;
    logic              rvalid_b_d, rvalid_b_q;

    always_comb begin
        rword_a = entry_q[raddr_a];
        rword_b = entry_q[raddr_b];
`ifdef RF_BYPASS_EN
        if (we && (waddr == raddr_a) && (raddr_a != RF_ZERO_REG)) begin
            rword_a = wdata;
        end
        if (we && (waddr == raddr_b) && (raddr_b != RF_ZERO_REG)) begin
            rword_b = wdata;
        end
`endif
    end

    always_comb begin
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        rvalid_a_d = rd_en_a;
        rvalid_b_d = rd_en_b;
        if (rd_en_a) begin
            rdata_a_d = rword_a;
        end
        if (rd_en_b) begin
            rdata_b_d = rword_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;

endmodule
